pio_ext: RTL and testbench

PIO_EXT -- requirements
Module: pio_ext

---
 rtl/pio_ext_pkg.sv | 20 ++
 rtl/pio_ext_sync.sv | 48 ++++
 rtl/pio_ext.sv | 142 ++++++++++++++
 tb/tb_pio_ext.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pio_ext_pkg.sv
// Shared constants for the PIO extension: register map, edge-mode encoding and
// blink counter width.
package pio_ext_pkg;

    localparam logic [2:0] ADDR_DATA         = 3'd0;
    localparam logic [2:0] ADDR_DIR          = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK     = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP     = 3'd3;
    localparam logic [2:0] ADDR_OUTSET       = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR       = 3'd5;
    localparam logic [2:0] ADDR_BLINK_EN     = 3'd6;
    localparam logic [2:0] ADDR_BLINK_PERIOD = 3'd7;

    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_ANY  = 2;

    localparam int unsigned BLINK_W = 24;

endpackage

// File: rtl/pio_ext_sync.sv
// Multi-flop synchroniser for the asynchronous pins plus an edge detector on
// the synchronised value.
module pio_ext_sync
    import pio_ext_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_MODE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pio_in,
    output logic [WIDTH-1:0] in_sync,
    output logic [WIDTH-1:0] in_edge
);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;

    // prev_q resets to 0 so a pin already high at release shows as one rising edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                stage_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            stage_q[0] <= pio_in;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
            prev_q <= stage_q[SYNC_STAGES-1];
        end
    end

    assign in_sync = stage_q[SYNC_STAGES-1];

    always_comb begin
        if (EDGE_MODE == EDGE_FALL) begin
            in_edge = ~in_sync & prev_q;
        end else if (EDGE_MODE == EDGE_ANY) begin
            in_edge = in_sync ^ prev_q;
        end else begin
            in_edge = in_sync & ~prev_q;
        end
    end

endmodule

// File: rtl/pio_ext.sv
// Avalon-MM PIO with direction control, edge capture interrupts, atomic
// set/clear and a shared blink generator.
module pio_ext
    import pio_ext_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [31:0] RESET_OUT   = 32'h0,
    parameter int unsigned EDGE_MODE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    input  logic [WIDTH-1:0] pio_in,
    output logic [WIDTH-1:0] pio_out,
    output logic [WIDTH-1:0] pio_oe
);

    localparam logic [BLINK_W-1:0] CNT_ONE = 1;

    logic [WIDTH-1:0]   out_q, out_d, dir_q, dir_d, mask_q, mask_d, cap_q, cap_d;
    logic [WIDTH-1:0]   blink_en_q, blink_en_d, cap_clr, pio_out_q, pio_out_d;
    logic [WIDTH-1:0]   in_sync, in_edge, wr_data;
    logic [BLINK_W-1:0] period_q, period_d, cnt_q, cnt_d;
    logic               phase_q, phase_d, period_wr, irq_q;
    logic [31:0]        readdata_q, rd_mux;

    pio_ext_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_MODE   (EDGE_MODE)
    ) u_sync (
        .clk     (clk),
        .reset   (reset),
        .pio_in  (pio_in),
        .in_sync (in_sync),
        .in_edge (in_edge)
    );

    assign wr_data = writedata[WIDTH-1:0];

    always_comb begin
        out_d      = out_q;
        dir_d      = dir_q;
        mask_d     = mask_q;
        blink_en_d = blink_en_q;
        period_d   = period_q;
        cap_clr    = '0;
        period_wr  = 1'b0;
        if (write) begin
            case (address)
                ADDR_DATA:         out_d      = wr_data;
                ADDR_DIR:          dir_d      = wr_data;
                ADDR_IRQ_MASK:     mask_d     = wr_data;
                ADDR_EDGE_CAP:     cap_clr    = wr_data;
                ADDR_OUTSET:       out_d      = out_q | wr_data;
                ADDR_OUTCLR:       out_d      = out_q & ~wr_data;
                ADDR_BLINK_EN:     blink_en_d = wr_data;
                ADDR_BLINK_PERIOD: begin
                    period_d  = writedata[BLINK_W-1:0];
                    period_wr = 1'b1;
                end
                default: ;
            endcase
        end
        // A new edge wins over a simultaneous W1C on the same bit
        cap_d = (cap_q & ~cap_clr) | in_edge;
    end

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (period_wr) begin
            cnt_d   = period_d;
            phase_d = 1'b0;
        end else if (period_q == '0) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == '0) begin
            cnt_d   = period_q;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q - CNT_ONE;
        end
        pio_out_d = out_d ^ (blink_en_d & {WIDTH{phase_d}});
    end

    // Read mux sees only current register state, so a same-cycle write is not visible
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:         rd_mux = 32'((dir_q & out_q) | (~dir_q & in_sync));
            ADDR_DIR:          rd_mux = 32'(dir_q);
            ADDR_IRQ_MASK:     rd_mux = 32'(mask_q);
            ADDR_EDGE_CAP:     rd_mux = 32'(cap_q);
            ADDR_BLINK_EN:     rd_mux = 32'(blink_en_q);
            ADDR_BLINK_PERIOD: rd_mux = 32'(period_q);
            default:           rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q      <= RESET_OUT[WIDTH-1:0];
            pio_out_q  <= RESET_OUT[WIDTH-1:0];
            dir_q      <= '0;
            mask_q     <= '0;
            cap_q      <= '0;
            blink_en_q <= '0;
            period_q   <= '0;
            cnt_q      <= '0;
            phase_q    <= 1'b0;
            irq_q      <= 1'b0;
            readdata_q <= '0;
        end else begin
            out_q      <= out_d;
            pio_out_q  <= pio_out_d;
            dir_q      <= dir_d;
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            blink_en_q <= blink_en_d;
            period_q   <= period_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            irq_q      <= |(cap_q & mask_q);
            if (read) begin
                readdata_q <= rd_mux;
            end
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;
    assign pio_out  = pio_out_q;
    assign pio_oe   = dir_q;

endmodule

// File: tb/tb_pio_ext.sv
// Directed self-checking bench for pio_ext (WIDTH=4, SYNC_STAGES=2, rising edges).
module tb_pio_ext;
    import pio_ext_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        irq;
    logic [3:0]  pio_in = '0;
    logic [3:0]  pio_out;
    logic [3:0]  pio_oe;

    int checks = 0;
    int errors = 0;

    pio_ext #(
        .WIDTH       (4),
        .SYNC_STAGES (2),
        .RESET_OUT   (32'h0),
        .EDGE_MODE   (EDGE_RISE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq),
        .pio_in    (pio_in),
        .pio_out   (pio_out),
        .pio_oe    (pio_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address   = a;
        writedata = d;
        write     = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a;
        read    = 1'b1;
        @(negedge clk);
        read = 1'b0;
        d    = readdata;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        seen;

        // Reset values
        wait_cycles(3);
        check("rst_pio_out", 32'(pio_out), 32'h0);
        check("rst_pio_oe", 32'(pio_oe), 32'h0);
        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        reset = 1'b0;

        // DIR=F, DATA=5
        bus_write(ADDR_DIR, 32'hF);
        bus_write(ADDR_DATA, 32'h5);
        check("dir_oe", 32'(pio_oe), 32'hF);
        check("data_out", 32'(pio_out), 32'h5);
        bus_read(ADDR_DATA, rd);
        check("data_rd", rd, 32'h5);

        // OUTSET / OUTCLR
        bus_write(ADDR_OUTSET, 32'h2);
        check("outset", 32'(pio_out), 32'h7);
        bus_read(ADDR_OUTSET, rd);
        check("outset_rd0", rd, 32'h0);
        bus_write(ADDR_OUTCLR, 32'h1);
        check("outclr", 32'(pio_out), 32'h6);

        // Mixed direction readback: (3 & 6) | (~3 & C) = E
        bus_write(ADDR_DIR, 32'h3);
        pio_in = 4'hC;
        wait_cycles(3);
        bus_read(ADDR_DATA, rd);
        check("data_mixed", rd, 32'hE);

        // Upper write bits ignored
        bus_write(ADDR_IRQ_MASK, 32'hFFFF_FFF0);
        bus_read(ADDR_IRQ_MASK, rd);
        check("mask_hi_bits", rd, 32'h0);

        // Same-cycle read and write returns pre-write value
        @(negedge clk);
        address   = ADDR_IRQ_MASK;
        writedata = 32'h3;
        write     = 1'b1;
        read      = 1'b1;
        @(negedge clk);
        write = 1'b0;
        read  = 1'b0;
        check("rw_same_old", readdata, 32'h0);
        bus_read(ADDR_IRQ_MASK, rd);
        check("rw_same_new", rd, 32'h3);

        // Falling edges are not captured; clear earlier captures
        bus_write(ADDR_DIR, 32'h0);
        bus_write(ADDR_IRQ_MASK, 32'h1);
        pio_in = 4'h0;
        wait_cycles(4);
        bus_write(ADDR_EDGE_CAP, 32'hF);
        bus_read(ADDR_EDGE_CAP, rd);
        check("cap_clear", rd, 32'h0);
        check("irq_idle", 32'(irq), 32'h0);

        // Rising edge on bit 0 -> capture and irq within SYNC_STAGES+3 cycles
        @(negedge clk);
        pio_in = 4'h1;
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(negedge clk);
            seen = irq;
        end
        check("irq_rise", 32'(seen), 32'h1);
        bus_read(ADDR_EDGE_CAP, rd);
        check("cap_bit0", rd, 32'h1);
        bus_write(ADDR_EDGE_CAP, 32'h1);
        check("irq_hold", 32'(irq), 32'h1);
        @(negedge clk);
        check("irq_clear", 32'(irq), 32'h0);

        // W1C on bit 2 in the same cycle as a new edge on bit 2
        @(negedge clk);
        pio_in = 4'h5;
        wait_cycles(2);
        address   = ADDR_EDGE_CAP;
        writedata = 32'h4;
        write     = 1'b1;
        @(negedge clk);
        write = 1'b0;
        bus_read(ADDR_EDGE_CAP, rd);
        check("w1c_vs_edge", rd, 32'h4);
        bus_write(ADDR_EDGE_CAP, 32'h4);
        bus_read(ADDR_EDGE_CAP, rd);
        check("w1c_plain", rd, 32'h0);
        pio_in = 4'h1;
        wait_cycles(4);
        bus_read(ADDR_EDGE_CAP, rd);
        check("no_fall_cap", rd, 32'h0);

        // Blink bit 3 with period 3: phase toggles every 4 cycles
        bus_write(ADDR_DIR, 32'hF);
        bus_write(ADDR_DATA, 32'h0);
        bus_write(ADDR_BLINK_EN, 32'h8);
        bus_write(ADDR_BLINK_PERIOD, 32'hAB00_0003);
        for (int k = 0; k < 13; k++) begin
            if (k > 0) @(negedge clk);
            check($sformatf("blink_k%0d", k), 32'(pio_out), ((k / 4) % 2 == 1) ? 32'h8 : 32'h0);
        end
        bus_read(ADDR_BLINK_PERIOD, rd);
        check("period_rd", rd, 32'h3);
        bus_write(ADDR_BLINK_PERIOD, 32'h0);
        for (int k = 0; k < 6; k++) begin
            check("blink_off", 32'(pio_out), 32'h0);
            @(negedge clk);
        end

        // Reset while blinking with a read in flight
        pio_in = 4'h5;
        bus_write(ADDR_BLINK_PERIOD, 32'h1);
        wait_cycles(2);
        @(negedge clk);
        address = ADDR_DIR;
        read    = 1'b1;
        @(posedge clk);
        #1;
        check("pre_rst_rd", readdata, 32'hF);
        reset = 1'b1;
        #1;
        check("arst_readdata", readdata, 32'h0);
        check("arst_pio_out", 32'(pio_out), 32'h0);
        check("arst_pio_oe", 32'(pio_oe), 32'h0);
        check("arst_irq", 32'(irq), 32'h0);
        read = 1'b0;
        wait_cycles(2);
        reset = 1'b0;

        // Pins already high at release register as rising edges
        wait_cycles(3);
        bus_read(ADDR_EDGE_CAP, rd);
        check("post_rst_cap", rd, 32'h5);
        bus_read(ADDR_BLINK_PERIOD, rd);
        check("post_rst_period", rd, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
